// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, byte/half/word access to a word-organised
// data memory (32-bit words, four little-endian byte lanes), MEM/WB register, forwarding view and debug read port.
module mem_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_store_data,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic               i_reg_write,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_mem_to_reg,
  input  logic [1:0]         i_mem_size,
  input  logic               i_unsigned,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_fwd_value,
  output logic [NB_REG-1:0]  o_fwd_rd,
  output logic               o_fwd_reg_write,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_REG-1:0]  o_rd,
  output logic               o_reg_write,
  output logic               o_mem_to_reg,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_dbg_data
);

  typedef struct packed {
    logic [NB_DATA-1:0] alu;
    logic [NB_DATA-1:0] sd;
    logic [NB_REG-1:0]  rd;
    logic               rw;
    logic               mr;
    logic               mw;
    logic               m2r;
    logic [1:0]         size;
    logic               uns;
  } exm_t;

  typedef struct packed {
    logic [NB_DATA-1:0] alu;
    logic [NB_DATA-1:0] rdata;
    logic [NB_REG-1:0]  rd;
    logic               rw;
    logic               m2r;
    logic               mis;
  } mwb_t;

  exm_t               exm_q, exm_d;
  mwb_t               mwb_q, mwb_d;
  logic [NB_DATA-1:0] dbg_q;
  logic [NB_DATA-1:0] mem_q [0:(1<<NB_ADDR)-1];

  logic [NB_ADDR-1:0] idx;
  logic [1:0]         lane;
  logic               misaligned;
  logic               mem_we;
  logic [3:0]         be;
  logic [NB_DATA-1:0] wdata;
  logic [NB_DATA-1:0] rd_word;
  logic [NB_DATA-1:0] shifted;
  logic [NB_DATA-1:0] load_data;
  logic               unused_hi_addr;

  assign idx            = exm_q.alu[NB_ADDR+1:2];
  assign lane           = exm_q.alu[1:0];
  assign unused_hi_addr = ^exm_q.alu[NB_DATA-1:NB_ADDR+2];

  // Stall has priority over flush; a flush still loads the data fields.
  always_comb begin
    exm_d = exm_q;
    if (!i_stall) begin
      exm_d.alu  = i_alu_result;
      exm_d.sd   = i_store_data;
      exm_d.rd   = i_rd;
      exm_d.rw   = i_reg_write  & ~i_flush;
      exm_d.mr   = i_mem_read   & ~i_flush;
      exm_d.mw   = i_mem_write  & ~i_flush;
      exm_d.m2r  = i_mem_to_reg & ~i_flush;
      exm_d.size = i_mem_size;
      exm_d.uns  = i_unsigned;
    end
  end

  always_comb begin
    misaligned = 1'b0;
    if (exm_q.mr || exm_q.mw) begin
      case (exm_q.size)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = lane[0];
        default: misaligned = |lane;
      endcase
    end
  end

  always_comb begin
    be    = 4'b0000;
    wdata = exm_q.sd;
    case (exm_q.size)
      2'b00: begin
        be          = 4'b0001 << lane;
        wdata[31:0] = {4{exm_q.sd[7:0]}};
      end
      2'b01: begin
        be          = lane[1] ? 4'b1100 : 4'b0011;
        wdata[31:0] = {2{exm_q.sd[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign mem_we = i_rst_n & ~i_stall & exm_q.mw & ~misaligned;

  // Memory contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  always_comb begin
    rd_word   = mem_q[idx];
    shifted   = rd_word >> {lane, 3'b000};
    load_data = '0;
    if (exm_q.mr && !misaligned) begin
      case (exm_q.size)
        2'b00:   load_data = {{(NB_DATA-8){~exm_q.uns & shifted[7]}}, shifted[7:0]};
        2'b01:   load_data = {{(NB_DATA-16){~exm_q.uns & shifted[15]}}, shifted[15:0]};
        default: load_data = rd_word;
      endcase
    end
  end

  always_comb begin
    mwb_d = mwb_q;
    if (!i_stall) begin
      mwb_d.alu   = exm_q.alu;
      mwb_d.rdata = load_data;
      mwb_d.rd    = exm_q.rd;
      mwb_d.rw    = exm_q.rw & ~misaligned;
      mwb_d.m2r   = exm_q.m2r;
      mwb_d.mis   = misaligned;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exm_q <= '0;
      mwb_q <= '0;
      dbg_q <= '0;
    end else begin
      exm_q <= exm_d;
      mwb_q <= mwb_d;
      dbg_q <= mem_q[i_dbg_addr];
    end
  end

  assign o_fwd_value     = exm_q.alu;
  assign o_fwd_rd        = exm_q.rd;
  assign o_fwd_reg_write = exm_q.rw;
  assign o_alu_result    = mwb_q.alu;
  assign o_read_data     = mwb_q.rdata;
  assign o_rd            = mwb_q.rd;
  assign o_reg_write     = mwb_q.rw;
  assign o_mem_to_reg    = mwb_q.m2r;
  assign o_misaligned    = mwb_q.mis;
  assign o_dbg_data      = dbg_q;

endmodule
